// File: rtl/usb_tx_encoder_pkg.sv
// Shared definitions for the USB transmit encoder: line states, field
// lengths and the encoder state and field types.
package usb_tx_pkg;

    // Line states encoded as {d_plus, d_minus}
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    localparam logic [4:0] SYNC_LEN  = 5'd8;
    localparam logic [4:0] PID_LEN   = 5'd8;
    localparam logic [4:0] CRC5_LEN  = 5'd5;
    localparam logic [4:0] CRC16_LEN = 5'd16;
    localparam logic [4:0] BYTE_LEN  = 5'd8;

    // SEND_HOLD: a field has finished or been aborted; line held until next load
    typedef enum logic [1:0] {
        SEND_IDLE,
        SEND_FIELD,
        SEND_HOLD,
        SEND_EOP
    } enc_state_t;

    typedef enum logic [2:0] {
        FLD_SYNC  = 3'd0,
        FLD_PID   = 3'd1,
        FLD_CRC5  = 3'd2,
        FLD_CRC16 = 3'd3,
        FLD_DATA  = 3'd4
    } field_t;

    function automatic logic [4:0] field_len(input field_t f);
        case (f)
            FLD_SYNC:  field_len = SYNC_LEN;
            FLD_PID:   field_len = PID_LEN;
            FLD_CRC5:  field_len = CRC5_LEN;
            FLD_CRC16: field_len = CRC16_LEN;
            default:   field_len = BYTE_LEN;
        endcase
    endfunction

endpackage

// File: rtl/usb_tx_encoder_if.sv
// Control-FSM to transmit-encoder bundle: load strobes, field values,
// transmitting flags, upstream byte handshake, done pulses and line outputs.
interface usb_tx_encoder_if;
    logic        sync_load_enable;
    logic        pid_load_enable;
    logic        crc5_load_enable;
    logic        crc16_load_enable;
    logic        data_load_enable;
    logic        idle_transmitting;
    logic        sync_transmitting;
    logic        pid_transmitting;
    logic        crc5_transmitting;
    logic        crc16_transmitting;
    logic        data_transmitting;
    logic        eop_transmitting;
    logic [7:0]  trans_sync;
    logic [7:0]  trans_pid;
    logic [4:0]  trans_crc5;
    logic [15:0] trans_crc16;
    logic [7:0]  tx_data;
    logic        get_tx_data;
    logic        sync_bits_transmitted;
    logic        pid_bits_transmitted;
    logic        crc5_bits_transmitted;
    logic        crc16_bits_transmitted;
    logic        data_bits_transmitted;
    logic        d_plus;
    logic        d_minus;

    modport master (
        output sync_load_enable, pid_load_enable, crc5_load_enable,
               crc16_load_enable, data_load_enable,
               idle_transmitting, sync_transmitting, pid_transmitting,
               crc5_transmitting, crc16_transmitting, data_transmitting,
               eop_transmitting,
               trans_sync, trans_pid, trans_crc5, trans_crc16, tx_data,
        input  get_tx_data,
               sync_bits_transmitted, pid_bits_transmitted,
               crc5_bits_transmitted, crc16_bits_transmitted,
               data_bits_transmitted,
               d_plus, d_minus
    );

    modport slave (
        input  sync_load_enable, pid_load_enable, crc5_load_enable,
               crc16_load_enable, data_load_enable,
               idle_transmitting, sync_transmitting, pid_transmitting,
               crc5_transmitting, crc16_transmitting, data_transmitting,
               eop_transmitting,
               trans_sync, trans_pid, trans_crc5, trans_crc16, tx_data,
        output get_tx_data,
               sync_bits_transmitted, pid_bits_transmitted,
               crc5_bits_transmitted, crc16_bits_transmitted,
               data_bits_transmitted,
               d_plus, d_minus
    );
endinterface

// File: rtl/usb_tx_encoder_nrzi_driver.sv
// NRZI line driver: holds the NRZI level and registers D+/D-.
// A 0 bit toggles J<->K, a 1 bit holds; SE0 and idle override the encoder.
module usb_nrzi_driver
    import usb_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bit_i,
    input  logic bit_strobe_i,
    input  logic force_se0_i,
    input  logic force_idle_i,
    output logic d_plus_o,
    output logic d_minus_o
);

    logic       level_q, level_d;   // 1 = J, 0 = K
    logic [1:0] line_q, line_d;

    // Next level and line: idle forces J, SE0 leaves the level untouched
    always_comb begin
        level_d = level_q;
        line_d  = line_q;
        if (force_idle_i) begin
            level_d = 1'b1;
            line_d  = J;
        end else if (force_se0_i) begin
            line_d  = SE0;
        end else if (bit_strobe_i) begin
            level_d = bit_i ? level_q : ~level_q;
            line_d  = level_d ? J : K;
        end
    end

    // Level and line registers, reset to J
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b1;
            line_q  <= J;
        end else begin
            level_q <= level_d;
            line_q  <= line_d;
        end
    end

    assign d_plus_o  = line_q[1];
    assign d_minus_o = line_q[0];

endmodule

// File: rtl/usb_tx_encoder.sv
// USB transmit encoder: serialises fields LSB-first, NRZI-encodes them and
// drives D+/D-, pulsing a done strobe per field back to the control FSM.
// Optional bit stuffing is enabled by defining USB_TX_BIT_STUFF_EN.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DATA_BYTES   = 8
) (
    input  logic               clk,
    input  logic               rst,
    usb_tx_encoder_if.slave    bus
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BYTE_LAST  = 3'(DATA_BYTES - 1);

    enc_state_t     state_q, state_d;
    field_t         field_q, field_d;
    logic [15:0]    shift_q, shift_d;
    logic [4:0]     len_q, len_d;
    logic [4:0]     bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [2:0]     byte_q, byte_d;
    logic           get_q, get_d;
    logic [4:0]     done_q, done_d;
`ifdef USB_TX_BIT_STUFF_EN
    logic [2:0]     stuff_cnt_q, stuff_cnt_d;
    logic           in_stuff_q, in_stuff_d;     // current bit period is a stuffed 0
    logic           last_sent_q, last_sent_d;   // last field bit sent, stuff bit still owed
`endif

    logic any_load, field_flag, timer_last, bit_last;
    logic bit_end, field_end;
    logic nrzi_bit, nrzi_strobe, force_se0, force_idle;

    assign any_load   = bus.sync_load_enable | bus.pid_load_enable | bus.crc5_load_enable |
                        bus.crc16_load_enable | bus.data_load_enable;
    assign timer_last = (timer_q == TIMER_LAST);
    assign bit_last   = (bit_cnt_q == len_q - 5'd1);

    // Transmitting flag belonging to the field currently loaded
    always_comb begin
        case (field_q)
            FLD_SYNC:  field_flag = bus.sync_transmitting;
            FLD_PID:   field_flag = bus.pid_transmitting;
            FLD_CRC5:  field_flag = bus.crc5_transmitting;
            FLD_CRC16: field_flag = bus.crc16_transmitting;
            FLD_DATA:  field_flag = bus.data_transmitting;
            default:   field_flag = 1'b0;
        endcase
    end

    // Next-state, shift/count control and line-driver requests
    always_comb begin
        state_d     = state_q;
        field_d     = field_q;
        shift_d     = shift_q;
        len_d       = len_q;
        bit_cnt_d   = bit_cnt_q;
        timer_d     = timer_q;
        byte_d      = byte_q;
        get_d       = 1'b0;
        done_d      = '0;
        nrzi_bit    = 1'b1;
        nrzi_strobe = 1'b0;
        force_se0   = 1'b0;
        force_idle  = 1'b0;
        bit_end     = 1'b0;
        field_end   = 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
        stuff_cnt_d = stuff_cnt_q;
        in_stuff_d  = in_stuff_q;
        last_sent_d = last_sent_q;
`endif
        if (any_load) begin
            state_d   = SEND_FIELD;
            bit_cnt_d = '0;
            timer_d   = '0;
`ifdef USB_TX_BIT_STUFF_EN
            in_stuff_d  = 1'b0;
            last_sent_d = 1'b0;
`endif
            if (bus.sync_load_enable) begin
                field_d = FLD_SYNC;
                shift_d = {8'h00, bus.trans_sync};
            end else if (bus.pid_load_enable) begin
                field_d = FLD_PID;
                shift_d = {8'h00, bus.trans_pid};
            end else if (bus.crc5_load_enable) begin
                field_d = FLD_CRC5;
                shift_d = {11'h000, bus.trans_crc5};
            end else if (bus.crc16_load_enable) begin
                field_d = FLD_CRC16;
                shift_d = bus.trans_crc16;
            end else begin
                field_d = FLD_DATA;
                shift_d = {8'h00, bus.tx_data};
                byte_d  = '0;
                get_d   = 1'b1;
            end
            len_d = field_len(field_d);
        end else if (bus.eop_transmitting) begin
            state_d   = SEND_EOP;
            force_se0 = 1'b1;
            bit_cnt_d = '0;
            timer_d   = '0;
`ifdef USB_TX_BIT_STUFF_EN
            stuff_cnt_d = '0;
`endif
        end else if (bus.idle_transmitting) begin
            state_d    = SEND_IDLE;
            force_idle = 1'b1;
            bit_cnt_d  = '0;
            timer_d    = '0;
`ifdef USB_TX_BIT_STUFF_EN
            stuff_cnt_d = '0;
`endif
        end else if (state_q == SEND_FIELD) begin
            if (!field_flag) begin
                // Flag dropped mid-field: abort silently
                state_d   = SEND_HOLD;
                bit_cnt_d = '0;
                timer_d   = '0;
`ifdef USB_TX_BIT_STUFF_EN
                in_stuff_d  = 1'b0;
                last_sent_d = 1'b0;
`endif
            end else begin
                timer_d = timer_last ? '0 : timer_q + 1'b1;
                if (timer_q == '0) begin
                    nrzi_strobe = 1'b1;
`ifdef USB_TX_BIT_STUFF_EN
                    if (stuff_cnt_q == 3'd6) begin
                        nrzi_bit    = 1'b0;
                        stuff_cnt_d = '0;
                        in_stuff_d  = 1'b1;
                    end else begin
                        nrzi_bit    = shift_q[0];
                        stuff_cnt_d = shift_q[0] ? stuff_cnt_q + 3'd1 : 3'd0;
                        in_stuff_d  = 1'b0;
                    end
`else
                    nrzi_bit = shift_q[0];
`endif
                end
                if (timer_last) begin
`ifdef USB_TX_BIT_STUFF_EN
                    // A stuff bit owed after the last bit is sent before finishing
                    if (in_stuff_q)
                        field_end = last_sent_q;
                    else if (bit_last) begin
                        if (stuff_cnt_q == 3'd6)
                            last_sent_d = 1'b1;
                        else
                            field_end = 1'b1;
                    end else
                        bit_end = 1'b1;
`else
                    if (bit_last)
                        field_end = 1'b1;
                    else
                        bit_end = 1'b1;
`endif
                end
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
                if (field_end) begin
`ifdef USB_TX_BIT_STUFF_EN
                    last_sent_d = 1'b0;
`endif
                    bit_cnt_d = '0;
                    if (field_q == FLD_DATA && byte_q != BYTE_LAST) begin
                        shift_d = {8'h00, bus.tx_data};
                        byte_d  = byte_q + 3'd1;
                        get_d   = 1'b1;
                    end else begin
                        done_d[field_q] = 1'b1;
                        state_d         = SEND_HOLD;
                        if (field_q == FLD_DATA)
                            byte_d = '0;
                    end
                end
            end
        end
    end

    // Encoder state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEND_IDLE;
            field_q   <= FLD_SYNC;
            shift_q   <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            byte_q    <= '0;
            get_q     <= 1'b0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            field_q   <= field_d;
            shift_q   <= shift_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            byte_q    <= byte_d;
            get_q     <= get_d;
            done_q    <= done_d;
        end
    end

`ifdef USB_TX_BIT_STUFF_EN
    // Bit-stuffing state, carried across field boundaries within a packet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuff_cnt_q <= '0;
            in_stuff_q  <= 1'b0;
            last_sent_q <= 1'b0;
        end else begin
            stuff_cnt_q <= stuff_cnt_d;
            in_stuff_q  <= in_stuff_d;
            last_sent_q <= last_sent_d;
        end
    end
`endif

    usb_nrzi_driver u_nrzi (
        .clk          (clk),
        .rst          (rst),
        .bit_i        (nrzi_bit),
        .bit_strobe_i (nrzi_strobe),
        .force_se0_i  (force_se0),
        .force_idle_i (force_idle),
        .d_plus_o     (bus.d_plus),
        .d_minus_o    (bus.d_minus)
    );

    assign bus.get_tx_data            = get_q;
    assign bus.sync_bits_transmitted  = done_q[FLD_SYNC];
    assign bus.pid_bits_transmitted   = done_q[FLD_PID];
    assign bus.crc5_bits_transmitted  = done_q[FLD_CRC5];
    assign bus.crc16_bits_transmitted = done_q[FLD_CRC16];
    assign bus.data_bits_transmitted  = done_q[FLD_DATA];

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Testbench for usb_tx_encoder: a reference NRZI/stuffing model pushes the
// expected line symbol of every bit period into a queue as each field is
// driven; symbols are popped mid-bit and compared against D+/D-.
module tb_usb_tx_encoder;
    import usb_tx_pkg::*;

    localparam int CPB = 4;
    localparam int NB  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    usb_tx_encoder_if bus ();

    usb_tx_encoder #(.CLKS_PER_BIT(CPB), .DATA_BYTES(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] exp_q[$];
    logic       m_level = 1'b1;  // model NRZI level, 1 = J
    int         m_ones  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [1:0] line();
        return {bus.d_plus, bus.d_minus};
    endfunction

    function automatic logic [4:0] done_vec();
        return {bus.data_bits_transmitted, bus.crc16_bits_transmitted,
                bus.crc5_bits_transmitted, bus.pid_bits_transmitted,
                bus.sync_bits_transmitted};
    endfunction

    function automatic logic [1:0] m_line();
        return m_level ? J : K;
    endfunction

    // Reference encoder: one data bit plus any stuff bit it triggers
    task automatic model_bit(input logic b);
        if (!b) m_level = ~m_level;
        exp_q.push_back(m_line());
`ifdef USB_TX_BIT_STUFF_EN
        m_ones = b ? m_ones + 1 : 0;
        if (m_ones == 6) begin
            m_level = ~m_level;
            exp_q.push_back(m_line());
            m_ones = 0;
        end
`endif
    endtask

    task automatic clear_ctrl();
        bus.sync_load_enable   = 1'b0;
        bus.pid_load_enable    = 1'b0;
        bus.crc5_load_enable   = 1'b0;
        bus.crc16_load_enable  = 1'b0;
        bus.data_load_enable   = 1'b0;
        bus.idle_transmitting  = 1'b0;
        bus.sync_transmitting  = 1'b0;
        bus.pid_transmitting   = 1'b0;
        bus.crc5_transmitting  = 1'b0;
        bus.crc16_transmitting = 1'b0;
        bus.data_transmitting  = 1'b0;
        bus.eop_transmitting   = 1'b0;
    endtask

    // kind: 0 sync, 1 pid, 2 crc5, 3 crc16, 4 data (bytes 0..NB-1)
    task automatic drive_field(input int kind, input logic [15:0] val);
        int len, nbytes, periods, done_at, done_cnt, get_cnt, idx;
        logic [15:0] v;
        logic [1:0]  prev;
        len    = (kind == 2) ? 5 : (kind == 3) ? 16 : 8;
        nbytes = (kind == 4) ? NB : 1;
        prev   = m_line();
        exp_q.delete();
        for (int b = 0; b < nbytes; b++) begin
            v = (kind == 4) ? 16'(b) : val;
            for (int i = 0; i < len; i++) model_bit(v[i]);
        end
        periods = exp_q.size();
        @(negedge clk);
        clear_ctrl();
        idx = 0;
        bus.tx_data = 8'h00;
        case (kind)
            0: begin bus.sync_load_enable  = 1'b1; bus.sync_transmitting  = 1'b1; bus.trans_sync  = val[7:0]; end
            1: begin bus.pid_load_enable   = 1'b1; bus.pid_transmitting   = 1'b1; bus.trans_pid   = val[7:0]; end
            2: begin bus.crc5_load_enable  = 1'b1; bus.crc5_transmitting  = 1'b1; bus.trans_crc5  = val[4:0]; end
            3: begin bus.crc16_load_enable = 1'b1; bus.crc16_transmitting = 1'b1; bus.trans_crc16 = val; end
            default: begin bus.data_load_enable = 1'b1; bus.data_transmitting = 1'b1; end
        endcase
        @(posedge clk);
        @(negedge clk);
        bus.sync_load_enable  = 1'b0;
        bus.pid_load_enable   = 1'b0;
        bus.crc5_load_enable  = 1'b0;
        bus.crc16_load_enable = 1'b0;
        bus.data_load_enable  = 1'b0;
        check("load_hold", line(), prev);
        done_at = -1; done_cnt = 0; get_cnt = 0;
        for (int n = 0; n <= 4 * periods + 4; n++) begin
            if (n > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            if (bus.get_tx_data) begin
                get_cnt++;
                idx++;
                bus.tx_data = 8'(idx);
            end
            if (done_vec() != 5'd0) begin
                done_cnt++;
                if (done_at < 0 && done_vec()[kind]) done_at = n;
            end
            if (n % 4 == 2 && exp_q.size() > 0) check("sym", line(), exp_q.pop_front());
        end
        check("done_cycle", done_at, 4 * periods);
        check("done_count", done_cnt, 1);
        check("end_hold", line(), m_line());
        if (kind == 4) check("get_count", get_cnt, NB);
    endtask

    task automatic eop_then_idle();
        @(negedge clk);
        clear_ctrl();
        bus.eop_transmitting = 1'b1;
        @(posedge clk); @(negedge clk);
        check("eop1", line(), SE0);
        @(posedge clk); @(negedge clk);
        check("eop2", line(), SE0);
        bus.eop_transmitting  = 1'b0;
        bus.idle_transmitting = 1'b1;
        @(posedge clk); @(negedge clk);
        check("idle_j", line(), J);
        m_level = 1'b1;
        m_ones  = 0;
    endtask

    initial begin
        int dcnt;
        clear_ctrl();
        bus.trans_sync = '0; bus.trans_pid = '0; bus.trans_crc5 = '0;
        bus.trans_crc16 = '0; bus.tx_data = '0;
        #12;
        check("rst_line", line(), J);
        check("rst_get", bus.get_tx_data, 0);
        check("rst_done", done_vec(), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.idle_transmitting = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_line", line(), J);

        // Packet: sync, pid, crc5, then EOP and idle
        drive_field(0, 16'h0080);
        drive_field(1, 16'h001E);
        drive_field(2, 16'h001F);
        eop_then_idle();

        // Sync from J again, then an 8-byte data field
        drive_field(0, 16'h0080);
        drive_field(4, 16'h0000);
        eop_then_idle();

        // All-ones CRC16: stuff bits when enabled
        drive_field(3, 16'hFFFF);
        eop_then_idle();

        // Reset mid-crc16
        @(negedge clk);
        clear_ctrl();
        bus.crc16_load_enable  = 1'b1;
        bus.crc16_transmitting = 1'b1;
        bus.trans_crc16        = 16'h0000;
        @(posedge clk); @(negedge clk);
        bus.crc16_load_enable = 1'b0;
        repeat (18) begin @(posedge clk); @(negedge clk); end
        check("pre_rst_line", line(), K);
        rst = 1'b1;
        #1;
        check("async_rst_line", line(), J);
        check("async_rst_done", done_vec(), 0);
        @(posedge clk); @(negedge clk);
        bus.crc16_transmitting = 1'b0;
        rst = 1'b0;
        dcnt = 0;
        repeat (10) begin
            @(posedge clk); @(negedge clk);
            if (done_vec() != 5'd0) dcnt++;
        end
        check("post_rst_nodone", dcnt, 0);
        m_level = 1'b1;
        m_ones  = 0;
        drive_field(0, 16'h0080);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the bench can never hang
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
